psum_wb_ctrl: RTL and testbench
===============================

PSUM_WB_CTRL -- requirements
Module: psum_wb_ctrl

Interface
REQ-001 SHALL have parameter col, default 8, meaning the number of output columns/SFP lanes.
REQ-002 SHALL have parameter psum_bw, default 16, meaning the per-column partial-sum width.
REQ-003 SHALL have parameter addr_w, default 11, meaning the PSUM SRAM address width.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse launching a pass; ignored while busy.
REQ-007 SHALL have port mode  in  2  00 passthrough (OFIFO->SRAM), 01 accumulate (SRAM+OFIFO->SRAM), 10 ReLU (SRAM->ReLU->SRAM), 11 reserved (treated as 10).
REQ-008 SHALL have port base_addr  in  addr_w  first SRAM row of the pass.
REQ-009 SHALL have port num_rows  in  addr_w  rows to process.
REQ-010 SHALL have port ofifo_valid  in  1  OFIFO head word available.
REQ-011 SHALL have port ofifo_out  in  col*psum_bw  OFIFO head word; column c at bits [c*psum_bw +: psum_bw].
REQ-012 SHALL have port ofifo_rd  out  1  pops OFIFO head this cycle.
REQ-013 SHALL have port psum_cen  out  1  SRAM chip enable, active-low.
REQ-014 SHALL have port psum_wen  out  1  SRAM write enable, active-low (1 = read).
REQ-015 SHALL have port psum_addr  out  addr_w  SRAM address.
REQ-016 SHALL have port psum_d  out  col*psum_bw  SRAM write data.
REQ-017 SHALL have port psum_q  in  col*psum_bw  SRAM read data, valid the cycle after a read (1-cycle latency).
REQ-018 SHALL have port busy  out  1  pass in progress.
REQ-019 SHALL have port done  out  1  one-cycle pulse at pass end.

Function
REQ-020 SHALL latch mode, base_addr, num_rows on an accepted start (start=1 while in IDLE).
REQ-021 SHALL implement states IDLE, FETCH, WAIT, WRITE, FIN.
REQ-022 SHALL go IDLE->FETCH on accepted start with num_rows!=0; IDLE->FIN when num_rows==0 (no SRAM or OFIFO activity).
REQ-023 SHALL, in FETCH for modes 00/01, stall until ofifo_valid=1, then assert ofifo_rd for exactly that cycle and capture ofifo_out into an internal row register.
REQ-024 SHALL, in FETCH for modes 01/10, issue an SRAM read (cen=0, wen=1, addr=current row) in the same cycle the FETCH completes; mode 00 issues no read.
REQ-025 SHALL go FETCH->WAIT for modes 01/10 and FETCH->WRITE for mode 00.
REQ-026 SHALL, in WAIT, sample psum_q into a row register and go to WRITE.
REQ-027 SHALL, in WRITE, drive cen=0, wen=0, addr=current row, psum_d=per-column lane result.
REQ-028 SHALL compute the lane result: mode 00 OFIFO word; 01 (psum+ofifo) mod 2^psum_bw, two's-complement wrap, no saturation; 10 0 if psum is negative as signed two's complement, else psum.
REQ-029 SHALL, after WRITE, increment the row address modulo 2^addr_w and decrement the remaining count; go to FETCH if the count is non-zero, else to FIN.
REQ-030 SHALL, in FIN, pulse done=1 for one cycle and return to IDLE.
REQ-031 SHALL hold busy=1 in all states except IDLE.
REQ-032 SHALL drive cen=1, wen=1, ofifo_rd=0 whenever no access is stated above.
REQ-033 SHALL have a throughput of 3 cycles/row in modes 01/10 and 2 cycles/row in mode 00, excluding OFIFO stalls.

Reset
REQ-034 SHALL, on reset_n=0, asynchronously enter IDLE and hold busy=0, done=0, ofifo_rd=0, cen=1, wen=1, psum_addr=0, psum_d=0.
REQ-035 SHALL abandon a mid-pass reset with no further SRAM write or OFIFO pop; rows already written stay written.

Structure
REQ-036 SHALL place state encodings and mode codes (MODE_PASS, MODE_ACC, MODE_RELU) in a shared package.
REQ-037 SHALL generate col instances of sub-module sfp, one per column, as the lane datapath.

Verification
REQ-038 SHALL verify: mode 01, base 5, 2 rows, SRAM[5] col0=0x0003, OFIFO col0=0xFFFE -> SRAM[5] col0=0x0001, done 6 cycles after start.
REQ-039 SHALL verify: mode 10, SRAM[0] col0=0x8000, col1=0x0007 -> SRAM[0] col0=0x0000, col1=0x0007; ofifo_rd never asserted.
REQ-040 SHALL verify: mode 00, ofifo_valid low 4 cycles then high -> no write before the pop; ofifo_rd pulses once per row.
REQ-041 SHALL verify: num_rows=0 -> done the cycle after FIN entry, cen stays 1.
REQ-042 SHALL verify: base 0x7FF, 2 rows -> writes to 0x7FF then 0x000.
REQ-043 SHALL verify: reset_n low in WAIT -> immediate IDLE, no write; start during busy ignored.

Source files
------------

// File: rtl/psum_wb_ctrl_pkg.sv
// Shared definitions for the partial-sum write-back controller: FSM states,
// pass mode codes and small mode-decode helpers.
package psum_wb_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_RELU = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // The reserved code behaves as ReLU, so fold it once when the pass is latched.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_RELU : m;
    endfunction

    function automatic logic uses_ofifo(input logic [1:0] m);
        return (m == MODE_PASS) || (m == MODE_ACC);
    endfunction

    function automatic logic uses_sram_read(input logic [1:0] m);
        return (m != MODE_PASS);
    endfunction

endpackage

// File: rtl/psum_wb_ctrl_sfp.sv
// Single-column special-function lane: passthrough, wrapping accumulate or ReLU.
module sfp
    import psum_wb_ctrl_pkg::*;
#(
    parameter int psum_bw = 16
) (
    input  logic [1:0]         mode,
    input  logic [psum_bw-1:0] psum,
    input  logic [psum_bw-1:0] ofifo,
    output logic [psum_bw-1:0] result
);

    // Per-lane result; the add simply drops the carry out, giving two's-complement wrap.
    always_comb begin
        result = {psum_bw{1'b0}};
        case (mode)
            MODE_PASS: result = ofifo;
            MODE_ACC:  result = psum + ofifo;
            MODE_RELU: result = psum[psum_bw-1] ? {psum_bw{1'b0}} : psum;
            default:   result = psum[psum_bw-1] ? {psum_bw{1'b0}} : psum;
        endcase
    end

endmodule

// File: rtl/psum_wb_ctrl.sv
// Row-by-row PSUM SRAM write-back controller: pops OFIFO rows and/or reads SRAM
// rows, runs them through col sfp lanes and writes the result back in place.
module psum_wb_ctrl
    import psum_wb_ctrl_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [addr_w-1:0]      base_addr,
    input  logic [addr_w-1:0]      num_rows,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   psum_cen,
    output logic                   psum_wen,
    output logic [addr_w-1:0]      psum_addr,
    output logic [col*psum_bw-1:0] psum_d,
    input  logic [col*psum_bw-1:0] psum_q,
    output logic                   busy,
    output logic                   done
);

    localparam logic [addr_w-1:0] ROW_ONE = {{(addr_w-1){1'b0}}, 1'b1};
    localparam logic [addr_w-1:0] ROW_ZERO = {addr_w{1'b0}};

    state_t                   state_r;
    state_t                   state_s;
    logic [1:0]               mode_r;
    logic [addr_w-1:0]        addr_r;
    logic [addr_w-1:0]        count_r;
    logic [col*psum_bw-1:0]   ofifo_row_r;
    logic [col*psum_bw-1:0]   psum_row_r;
    logic [col*psum_bw-1:0]   lane_s;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and SRAM/OFIFO strobes; ofifo_rd and the FETCH read must react
    // to ofifo_valid in the same cycle, so these are decoded from the state.
    always_comb begin
        state_s   = state_r;
        ofifo_rd  = 1'b0;
        psum_cen  = 1'b1;
        psum_wen  = 1'b1;
        psum_addr = addr_r;
        psum_d    = {(col*psum_bw){1'b0}};
        busy      = (state_r != ST_IDLE);
        done      = (state_r == ST_FIN);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = (num_rows == ROW_ZERO) ? ST_FIN : ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!uses_ofifo(mode_r) || ofifo_valid) begin
                    ofifo_rd = uses_ofifo(mode_r);
                    if (uses_sram_read(mode_r)) begin
                        psum_cen = 1'b0;
                        psum_wen = 1'b1;
                        state_s  = ST_WAIT;
                    end else begin
                        state_s  = ST_WRITE;
                    end
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                psum_cen = 1'b0;
                psum_wen = 1'b0;
                psum_d   = lane_s;
                state_s  = (count_r == ROW_ONE) ? ST_FIN : ST_FETCH;
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pass parameters, row pointer/count and the two row-capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r      <= MODE_PASS;
            addr_r      <= ROW_ZERO;
            count_r     <= ROW_ZERO;
            ofifo_row_r <= {(col*psum_bw){1'b0}};
            psum_row_r  <= {(col*psum_bw){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r  <= norm_mode(mode);
                        addr_r  <= base_addr;
                        count_r <= num_rows;
                    end
                end
                ST_FETCH: begin
                    if (ofifo_rd) begin
                        ofifo_row_r <= ofifo_out;
                    end
                end
                ST_WAIT: begin
                    psum_row_r <= psum_q;
                end
                ST_WRITE: begin
                    addr_r  <= addr_r + ROW_ONE;
                    count_r <= count_r - ROW_ONE;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_lane
        sfp #(
            .psum_bw(psum_bw)
        ) u_sfp (
            .mode   (mode_r),
            .psum   (psum_row_r[c*psum_bw +: psum_bw]),
            .ofifo  (ofifo_row_r[c*psum_bw +: psum_bw]),
            .result (lane_s[c*psum_bw +: psum_bw])
        );
    end

endmodule

// File: tb/tb_psum_wb_ctrl.sv
// Scoreboard bench for psum_wb_ctrl with a behavioural SRAM, a randomly stalling
// OFIFO and a row-level reference model of every write-back.
module tb_psum_wb_ctrl;

    localparam int COL   = 8;
    localparam int PBW   = 16;
    localparam int AW    = 11;
    localparam int W     = COL * PBW;
    localparam int DEPTH = 2048;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_rows;
    logic          ofifo_valid;
    logic [W-1:0]  ofifo_out;
    logic          ofifo_rd;
    logic          psum_cen;
    logic          psum_wen;
    logic [AW-1:0] psum_addr;
    logic [W-1:0]  psum_d;
    logic [W-1:0]  psum_q;
    logic          busy;
    logic          done;

    logic [W-1:0]  sram    [DEPTH];
    logic [W-1:0]  ref_mem [DEPTH];
    wr_t           exp_q [$];
    logic [W-1:0]  ofq [$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hold_until = 0;
    bit   rand_stall = 1'b0;
    bit   rd_seen = 1'b0;
    int   n_pops = 0;
    int   n_writes = 0;
    int   n_cen = 0;
    int   pops0 = 0;
    int   writes0 = 0;
    logic [1:0] cur_mode = 2'd0;

    psum_wb_ctrl #(.col(COL), .psum_bw(PBW), .addr_w(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .base_addr(base_addr), .num_rows(num_rows),
        .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
        .psum_cen(psum_cen), .psum_wen(psum_wen), .psum_addr(psum_addr),
        .psum_d(psum_d), .psum_q(psum_q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (!psum_cen) begin
            if (!psum_wen) sram[psum_addr] <= psum_d;
            else           psum_q <= sram[psum_addr];
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Reference row result, column by column, straight from the mode rules.
    function automatic logic [W-1:0] ref_row(input logic [1:0] m, input logic [W-1:0] p, input logic [W-1:0] o);
        logic [W-1:0]   r;
        logic [PBW-1:0] pv, ov;
        for (int c = 0; c < COL; c++) begin
            pv = p[c*PBW +: PBW];
            ov = o[c*PBW +: PBW];
            if (m == 2'd0)      r[c*PBW +: PBW] = ov;
            else if (m == 2'd1) r[c*PBW +: PBW] = PBW'((int'(pv) + int'(ov)) % 65536);
            else                r[c*PBW +: PBW] = ($signed(pv) < 0) ? PBW'(0) : pv;
        end
        return r;
    endfunction

    task automatic set_row(input int a, input logic [W-1:0] v);
        sram[a]    <= v;
        ref_mem[a] = v;
    endtask

    // Monitor: scoreboard for every SRAM write plus OFIFO/SRAM protocol checks.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            rd_seen = ofifo_rd;
            if (reset_n) begin
                if (!psum_cen) n_cen++;
                if (!psum_cen && psum_wen && cur_mode == 2'd0)
                    check("no_read_in_pass", W'(psum_cen), W'(1));
                if (ofifo_rd && cur_mode == 2'd2)
                    check("no_ofifo_rd_relu", W'(ofifo_rd), W'(0));
                if (ofifo_rd) n_pops++;
                if (!psum_cen && !psum_wen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", W'(psum_cen), W'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", W'(psum_addr), W'(e.addr));
                        check("write_data", psum_d, e.data);
                        if (cur_mode != 2'd2)
                            check("write_after_pop", W'((n_pops - pops0) > (n_writes - writes0)), W'(1));
                    end
                    n_writes++;
                end
            end
        end
    end

    // OFIFO model: head word presented while non-empty, popped on ofifo_rd.
    initial begin
        ofifo_valid = 1'b0;
        ofifo_out   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen && ofq.size() > 0) void'(ofq.pop_front());
            ofifo_valid = (ofq.size() > 0) && (cyc >= hold_until) &&
                          !(rand_stall && $urandom_range(0, 2) == 0);
            ofifo_out   = (ofq.size() > 0) ? ofq[0] : '0;
        end
    end

    task automatic run_pass(input logic [1:0] m, input logic [AW-1:0] base, input int n,
                            input int exp_lat, input bit inject,
                            input bit force0, input logic [PBW-1:0] col0v);
        logic [1:0]    em;
        logic [AW-1:0] a;
        logic [W-1:0]  o, r;
        int            lat, cen0;
        em = (m == 2'd3) ? 2'd2 : m;
        pops0 = n_pops;
        writes0 = n_writes;
        cen0 = n_cen;
        cur_mode = em;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            o = '0;
            if (em != 2'd2) begin
                o = rand_word();
                if (force0 && i == 0) o[PBW-1:0] = col0v;
                ofq.push_back(o);
            end
            r = ref_row(em, ref_mem[a], o);
            ref_mem[a] = r;
            exp_q.push_back('{a, r});
        end
        @(posedge clk);
        #1;
        mode = m; base_addr = base; num_rows = AW'(n); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 2'($urandom); base_addr = AW'($urandom); num_rows = AW'($urandom);
        lat = -1;
        for (int t = 1; t < 600; t++) begin
            @(negedge clk);
            if (t == 1) check("busy_in_pass", W'(busy), W'(1));
            if (inject && t == 2) start = 1'b1;
            if (inject && t == 3) start = 1'b0;
            if (done) begin
                lat = t - 1;
                break;
            end
        end
        if (lat < 0) begin
            check("done_timeout", W'(done), W'(1));
        end else begin
            if (exp_lat >= 0) check("done_latency", W'(lat), W'(exp_lat));
            @(negedge clk);
            check("done_one_cycle", W'(done), W'(0));
            check("idle_after_pass", W'(busy), W'(0));
        end
        check("scoreboard_drained", W'(exp_q.size()), W'(0));
        check("ofifo_pops", W'(n_pops - pops0), W'((em == 2'd2) ? 0 : n));
        if (n == 0) check("no_sram_activity", W'(n_cen - cen0), W'(0));
    endtask

    initial begin
        logic [W-1:0] v;
        reset_n = 1'b0; start = 1'b0; mode = 2'd0; base_addr = '0; num_rows = '0;
        for (int a = 0; a < DEPTH; a++) set_row(a, rand_word());
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_ofifo_rd", W'(ofifo_rd), W'(0));
        check("rst_cen", W'(psum_cen), W'(1));
        check("rst_wen", W'(psum_wen), W'(1));
        check("rst_addr", W'(psum_addr), W'(0));
        check("rst_d", psum_d, W'(0));
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Accumulate with wrap, two rows from base 5; a start mid-pass is ignored.
        v = rand_word(); v[PBW-1:0] = 16'h0003; set_row(5, v);
        run_pass(2'd1, AW'(5), 2, 6, 1'b1, 1'b1, 16'hFFFE);
        check("acc_sram5_col0", W'(sram[5][PBW-1:0]), W'(16'h0001));

        // ReLU on row 0: negative column cleared, positive one kept.
        v = rand_word(); v[15:0] = 16'h8000; v[31:16] = 16'h0007; set_row(0, v);
        run_pass(2'd2, AW'(0), 1, 3, 1'b0, 1'b0, 16'h0);
        check("relu_col0", W'(sram[0][15:0]), W'(16'h0000));
        check("relu_col1", W'(sram[0][31:16]), W'(16'h0007));

        // Passthrough with OFIFO empty-looking for the first cycles.
        hold_until = cyc + 5;
        run_pass(2'd0, AW'(20), 3, -1, 1'b0, 1'b0, 16'h0);
        hold_until = 0;

        // Zero rows, address wrap at the top of the SRAM, reserved mode.
        run_pass(2'd1, AW'(40), 0, 0, 1'b0, 1'b0, 16'h0);
        run_pass(2'd0, AW'(11'h7FF), 2, 4, 1'b0, 1'b0, 16'h0);
        run_pass(2'd3, AW'(100), 2, 6, 1'b0, 1'b0, 16'h0);

        // Reset asserted while the controller waits on the SRAM read.
        cur_mode = 2'd1;
        pops0 = n_pops;
        writes0 = n_writes;
        ofq.push_back(rand_word());
        @(posedge clk);
        #1;
        mode = 2'd1; base_addr = AW'(9); num_rows = AW'(1); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_cen", W'(psum_cen), W'(1));
        check("midrst_wen", W'(psum_wen), W'(1));
        check("midrst_done", W'(done), W'(0));
        check("midrst_d", psum_d, W'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_idle", W'(busy), W'(0));
        check("midrst_no_write", W'(n_writes - writes0), W'(0));
        check("midrst_one_pop", W'(n_pops - pops0), W'(1));

        // Randomised passes with a stalling OFIFO.
        rand_stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [1:0] m;
            int n;
            m = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 6);
            run_pass(m, AW'($urandom), n, (m[1]) ? 3 * n : -1, 1'b0, 1'b0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
